// File: rtl/mandelbrot_scan.sv
`timescale 1ns/1ps
// Raster-scan sequencer: walks a WIDTH x HEIGHT grid, drives the iteration engine, streams {x,y,value}.
// Latency: engine busy time + 4 cycles per pixel with pixel_ready held high.
// Backpressure: pixel word held until pixel_ready; no new engine start until the word is accepted.
module mandelbrot_scan #(
   parameter int          WIDTH   = 64,
   parameter int          HEIGHT  = 64,
   parameter logic [15:0] R_START = 16'hf800,
   parameter logic [15:0] I_START = 16'hfc00,
   parameter logic [15:0] R_STEP  = 16'h0030,
   parameter logic [15:0] I_STEP  = 16'h0020
) (
   input  logic        raw_clk,
   input  logic        reset_n,
   input  logic        go,
   output logic        running,
   output logic        mb_start,
   output logic [15:0] mb_curr_r,
   output logic [15:0] mb_curr_i,
   input  logic [3:0]  mb_result,
   input  logic        mb_busy,
   output logic        pixel_valid,
   input  logic        pixel_ready,
   output logic [9:0]  pixel_x,
   output logic [9:0]  pixel_y,
   output logic [3:0]  pixel_value,
   output logic        frame_done
);

   typedef enum logic [2:0] {
      IDLE,
      DRAIN,
      ISSUE,
      WAIT_BUSY,
      WAIT_DONE,
      OUTPUT,
      NEXT
   } state_t;

   localparam logic [9:0] X_LAST = 10'(WIDTH - 1);
   localparam logic [9:0] Y_LAST = 10'(HEIGHT - 1);

   state_t     state;
   state_t     state_nxt;
   logic [9:0] x;
   logic [9:0] y;
   logic       load;
   logic       accept;
   logic       capture;
   logic       step_col;
   logic       step_row;
   logic       finish;

   always_ff @(posedge raw_clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      mb_start    = 1'b0;
      pixel_valid = 1'b0;
      load        = 1'b0;
      accept      = 1'b0;
      capture     = 1'b0;
      step_col    = 1'b0;
      step_row    = 1'b0;
      finish      = 1'b0;
      case (state)
         IDLE: begin
            load = 1'b1;
            if (go) begin
               accept    = 1'b1;
               state_nxt = DRAIN;
            end
         end
         // The engine keeps no reset, so a job left over from before our reset must finish first.
         DRAIN: begin
            if (!mb_busy) state_nxt = ISSUE;
         end
         ISSUE: begin
            mb_start  = 1'b1;
            state_nxt = WAIT_BUSY;
         end
         // Only a rising busy proves the engine took the start; a low busy here is stale.
         WAIT_BUSY: begin
            if (mb_busy) state_nxt = WAIT_DONE;
         end
         WAIT_DONE: begin
            if (!mb_busy) begin
               capture   = 1'b1;
               state_nxt = OUTPUT;
            end
         end
         OUTPUT: begin
            pixel_valid = 1'b1;
            if (pixel_ready) state_nxt = NEXT;
         end
         NEXT: begin
            if (x < X_LAST) begin
               step_col  = 1'b1;
               state_nxt = ISSUE;
            end else if (y < Y_LAST) begin
               step_row  = 1'b1;
               state_nxt = ISSUE;
            end else begin
               finish    = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Coordinates only move in IDLE/NEXT, so they stay fixed while the engine iterates on them.
   always_ff @(posedge raw_clk or negedge reset_n) begin
      if (!reset_n) begin
         x           <= '0;
         y           <= '0;
         mb_curr_r   <= R_START;
         mb_curr_i   <= I_START;
         pixel_x     <= '0;
         pixel_y     <= '0;
         pixel_value <= '0;
         running     <= 1'b0;
         frame_done  <= 1'b0;
      end else begin
         frame_done <= finish;
         if (accept) begin
            running <= 1'b1;
         end else if (finish) begin
            running <= 1'b0;
         end
         if (load) begin
            x         <= '0;
            y         <= '0;
            mb_curr_r <= R_START;
            mb_curr_i <= I_START;
         end
         if (capture) begin
            pixel_x     <= x;
            pixel_y     <= y;
            pixel_value <= mb_result;
         end
         if (step_col) begin
            x         <= x + 10'd1;
            mb_curr_r <= mb_curr_r + R_STEP;
         end
         if (step_row) begin
            x         <= '0;
            mb_curr_r <= R_START;
            y         <= y + 10'd1;
            mb_curr_i <= mb_curr_i + I_STEP;
         end
      end
   end

endmodule
